// File: rtl/mips32_fetch_pkg.sv
// Shared definitions for the MIPS32 fetch stage: FSM states, reset PC and
// instruction field bit positions.
package mips32_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // MIPS text segment base
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    localparam int OPC_MSB    = 31;
    localparam int OPC_LSB    = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    // Branch displacement: sign-extended word offset converted to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and imem.
interface instruction_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch_next_pc.sv
// Combinational next-PC selection: jump, taken conditional branch, or sequential.
module next_pc
    import mips32_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic        is_jmp,
    input  logic        is_beq,
    input  logic        is_bne,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic branch_taken;

    // beq and bne may both be raised; either condition alone takes the branch
    assign branch_taken = (is_beq & alu_zero) | (is_bne & ~alu_zero);

    always_comb begin
        next_pc = pc_plus4;
        if (is_jmp) begin
            next_pc = {pc_plus4[31:28], target26, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset(imm16);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Multi-cycle MIPS32 fetch stage: holds the PC, fetches over a req/ack bus,
// exposes decoded fields during EXEC and advances the PC from control inputs.
module instruction_fetch
    import mips32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master imem,
    output logic [5:0]          opc,
    output logic [5:0]          func,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [15:0]         imm16,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    input  logic                is_jmp,
    input  logic                is_beq,
    input  logic                is_bne,
    input  logic                alu_zero,
    input  logic                inv_opcode,
    input  logic                exec_stall,
    output logic                halted
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  ir_reg, ir_next;
    logic [31:0]  next_pc_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    // imem_ack is only looked at in FETCH; a stray ack elsewhere is dropped
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem.ack) begin
                    ir_next    = imem.rdata;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (inv_opcode) begin
                    state_next = ST_HALT;
                end else if (!exec_stall) begin
                    pc_next    = next_pc_value;
                    state_next = ST_FETCH;
                end
            end
            default:  state_next = ST_HALT;
        endcase
    end

    always_comb begin
        imem.req    = (state_reg == ST_FETCH);
        imem.addr   = pc_reg;
        instr_valid = (state_reg == ST_EXEC);
        halted      = (state_reg == ST_HALT);
    end

    assign pc       = pc_reg;
    assign pc_plus4 = pc_reg + 32'd4;

    assign opc   = ir_reg[OPC_MSB:OPC_LSB];
    assign func  = ir_reg[FUNC_MSB:FUNC_LSB];
    assign rs    = ir_reg[RS_MSB:RS_LSB];
    assign rt    = ir_reg[RT_MSB:RT_LSB];
    assign rd    = ir_reg[RD_MSB:RD_LSB];
    assign imm16 = ir_reg[IMM_MSB:IMM_LSB];

    next_pc u_next_pc (
        .pc_plus4 (pc_plus4),
        .imm16    (ir_reg[IMM_MSB:IMM_LSB]),
        .target26 (ir_reg[TARGET_MSB:TARGET_LSB]),
        .is_jmp   (is_jmp),
        .is_beq   (is_beq),
        .is_bne   (is_bne),
        .alu_zero (alu_zero),
        .next_pc  (next_pc_value)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// instruction streams checked against an arithmetic next-PC / field model.
module tb_instruction_fetch;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_jmp, is_beq, is_bne, alu_zero, inv_opcode, exec_stall;
    logic [5:0]  opc, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        instr_valid, halted;
    logic [31:0] pc, pc_plus4;

    logic        w_tie;
    logic [5:0]  w_opc, w_func;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm16;
    logic        w_valid, w_halted;
    logic [31:0] w_pc, w_pc_plus4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instruction_fetch_if imem ();
    instruction_fetch_if w_imem ();

    instruction_fetch #(.RESET_PC(BASE)) dut (
        .clk(clk), .rst(rst), .imem(imem),
        .opc(opc), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .is_jmp(is_jmp), .is_beq(is_beq), .is_bne(is_bne), .alu_zero(alu_zero),
        .inv_opcode(inv_opcode), .exec_stall(exec_stall), .halted(halted)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .imem(w_imem),
        .opc(w_opc), .func(w_func), .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm16(w_imm16),
        .instr_valid(w_valid), .pc(w_pc), .pc_plus4(w_pc_plus4),
        .is_jmp(w_tie), .is_beq(w_tie), .is_bne(w_tie), .alu_zero(w_tie),
        .inv_opcode(w_tie), .exec_stall(w_tie), .halted(w_halted)
    );

    // Observations captured by run_instr for the calling scenario to judge
    logic        obs_fetch_req, obs_next_req, obs_halted;
    logic [31:0] obs_fetch_addr, obs_next_addr, obs_pc_exec;
    bit          obs_addr_stable, obs_fields_stable, obs_pc_stable;
    int          obs_valid_cycles;
    logic [5:0]  obs_opc, obs_func;
    logic [4:0]  obs_rs, obs_rt, obs_rd;
    logic [15:0] obs_imm;

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] instr,
                                             input bit j, input bit b, input bit n, input bit z);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(instr[15:0]));
        if (j) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
        if ((b && z) || (n && !z)) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: fetch with ack_delay wait cycles, run EXEC with stall_n extra cycles.
    task automatic run_instr(input logic [31:0] instr, input int ack_delay, input int stall_n,
                             input bit j, input bit b, input bit n, input bit z, input bit inv);
        obs_fetch_req   = imem.req;
        obs_fetch_addr  = imem.addr;
        obs_addr_stable = 1'b1;
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            if (imem.req !== 1'b1 || imem.addr !== obs_fetch_addr) obs_addr_stable = 1'b0;
        end
        imem.ack = 1'b1;
        imem.rdata = instr;
        tick();
        imem.ack = 1'b0;
        imem.rdata = $urandom;
        obs_opc = opc; obs_func = func; obs_rs = rs; obs_rt = rt; obs_rd = rd; obs_imm = imm16;
        obs_pc_exec = pc;
        obs_fields_stable = 1'b1;
        obs_pc_stable = 1'b1;
        is_jmp = j; is_beq = b; is_bne = n; alu_zero = z; inv_opcode = inv;
        obs_valid_cycles = 0;
        while (instr_valid === 1'b1 && obs_valid_cycles < 50) begin
            obs_valid_cycles++;
            if ({opc, func, rs, rt, rd, imm16} !== {obs_opc, obs_func, obs_rs, obs_rt, obs_rd, obs_imm})
                obs_fields_stable = 1'b0;
            if (pc !== obs_pc_exec) obs_pc_stable = 1'b0;
            exec_stall = (obs_valid_cycles <= stall_n);
            tick();
        end
        {is_jmp, is_beq, is_bne, alu_zero, inv_opcode, exec_stall} = '0;
        obs_next_addr = imem.addr;
        obs_next_req  = imem.req;
        obs_halted    = halted;
        $display("txn fetch=%h instr=%h wait=%0d stall=%0d j=%0d b=%0d n=%0d z=%0d inv=%0d -> next=%h req=%b",
                 obs_fetch_addr, instr, ack_delay, stall_n, j, b, n, z, inv, obs_next_addr, obs_next_req);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({imem.req, instr_valid, halted} !== 3'b000) begin
                miscompares++; $display("FAIL reset_ctl: req/valid/halted got %b expected 000", {imem.req, instr_valid, halted});
            end
            vectors++;
            if (pc !== BASE) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, BASE); end
            vectors++;
            if ({opc, func, rs, rt, rd, imm16} !== 43'd0) begin
                miscompares++; $display("FAIL reset_fields: got %h expected 0", {opc, func, rs, rt, rd, imm16});
            end
        end
        rst = 1'b0;
        vectors++;
        if (imem.req !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %b expected 0", imem.req); end
        tick();
        vectors++;
        if (imem.req !== 1'b1 || imem.addr !== BASE) begin
            miscompares++; $display("FAIL first_fetch: req=%b addr=%h expected req=1 addr=%h", imem.req, imem.addr, BASE);
        end
        vectors++;
        if (pc_plus4 !== BASE + 32'd4 || instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL first_fetch_misc: pc_plus4=%h valid=%b", pc_plus4, instr_valid);
        end
    endtask

    task automatic test_zero_wait;
        run_instr(32'h012A_4020, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs_valid_cycles !== 1) begin miscompares++; $display("FAIL zw_valid_cycles: got %0d expected 1", obs_valid_cycles); end
        vectors++;
        if ({obs_opc, obs_func, obs_rs, obs_rt, obs_rd} !== {6'd0, 6'h20, 5'd9, 5'd10, 5'd8}) begin
            miscompares++; $display("FAIL zw_fields: opc=%h func=%h rs=%0d rt=%0d rd=%0d expected 0 20 9 10 8",
                                    obs_opc, obs_func, obs_rs, obs_rt, obs_rd);
        end
        vectors++;
        if (obs_imm !== 16'h4020) begin miscompares++; $display("FAIL zw_imm: got %h expected 4020", obs_imm); end
        vectors++;
        if (obs_next_req !== 1'b1 || obs_next_addr !== 32'h0040_0004) begin
            miscompares++; $display("FAIL zw_next: req=%b addr=%h expected 1 00400004", obs_next_req, obs_next_addr);
        end
    endtask

    task automatic test_branch;
        run_instr(32'h0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h1000_FFFE, 0, 0, 0, 1, 0, 1, 0);
        vectors++;
        if (obs_fetch_addr !== 32'h0040_0008 || obs_next_addr !== 32'h0040_0004) begin
            miscompares++; $display("FAIL beq_taken: fetch=%h next=%h expected 00400008 00400004", obs_fetch_addr, obs_next_addr);
        end
        run_instr(32'h0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h1400_FFFE, 0, 0, 0, 0, 1, 1, 0);
        vectors++;
        if (obs_fetch_addr !== 32'h0040_0008 || obs_next_addr !== 32'h0040_000C) begin
            miscompares++; $display("FAIL bne_not_taken: fetch=%h next=%h expected 00400008 0040000c", obs_fetch_addr, obs_next_addr);
        end
    endtask

    task automatic test_jump;
        run_instr(32'h0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h0810_0040, 0, 0, 1, 1, 0, 1, 0);
        vectors++;
        if (obs_fetch_addr !== 32'h0040_0010 || obs_next_addr !== 32'h0040_0100) begin
            miscompares++; $display("FAIL jump_wins: fetch=%h next=%h expected 00400010 00400100", obs_fetch_addr, obs_next_addr);
        end
    endtask

    task automatic test_stall_delay;
        run_instr($urandom & 32'hFC00_FFFF, 3, 2, 0, 0, 0, 0, 0);
        vectors++;
        if (obs_addr_stable !== 1'b1) begin miscompares++; $display("FAIL delay_addr_stable: got %b expected 1", obs_addr_stable); end
        vectors++;
        if (obs_valid_cycles !== 3) begin miscompares++; $display("FAIL stall_valid_cycles: got %0d expected 3", obs_valid_cycles); end
        vectors++;
        if (obs_pc_stable !== 1'b1 || obs_fields_stable !== 1'b1) begin
            miscompares++; $display("FAIL stall_hold: pc_stable=%b fields_stable=%b expected 1 1", obs_pc_stable, obs_fields_stable);
        end
        vectors++;
        if (obs_next_addr !== 32'h0040_0104) begin miscompares++; $display("FAIL stall_next: got %h expected 00400104", obs_next_addr); end
    endtask

    task automatic test_random;
        logic [31:0] model_pc, instr, exp_next;
        int          d, s;
        bit          j, b, n, z;
        model_pc = 32'h0040_0104;
        for (int k = 0; k < 40; k++) begin
            instr = $urandom;
            d = $urandom_range(0, 3);
            s = $urandom_range(0, 2);
            j = ($urandom_range(0, 3) == 0);
            b = $urandom_range(0, 1) != 0;
            n = $urandom_range(0, 1) != 0;
            z = $urandom_range(0, 1) != 0;
            exp_next = ref_next(model_pc, instr, j, b, n, z);
            run_instr(instr, d, s, j, b, n, z, 0);
            vectors++;
            if (obs_fetch_addr !== model_pc || obs_addr_stable !== 1'b1) begin
                miscompares++; $display("FAIL rnd_fetch[%0d]: addr=%h stable=%b expected %h 1", k, obs_fetch_addr, obs_addr_stable, model_pc);
            end
            vectors++;
            if ({obs_opc, obs_func, obs_rs, obs_rt, obs_rd, obs_imm} !==
                {6'(instr >> 26), 6'(instr & 63), 5'(instr >> 21), 5'(instr >> 16), 5'(instr >> 11), 16'(instr)}) begin
                miscompares++; $display("FAIL rnd_fields[%0d]: got %h for instr %h", k,
                                        {obs_opc, obs_func, obs_rs, obs_rt, obs_rd, obs_imm}, instr);
            end
            vectors++;
            if (obs_valid_cycles !== s + 1 || obs_pc_stable !== 1'b1) begin
                miscompares++; $display("FAIL rnd_exec[%0d]: cycles=%0d pc_stable=%b expected %0d 1", k, obs_valid_cycles, obs_pc_stable, s + 1);
            end
            vectors++;
            if (obs_next_req !== 1'b1 || obs_next_addr !== exp_next) begin
                miscompares++; $display("FAIL rnd_next[%0d]: req=%b addr=%h expected 1 %h", k, obs_next_req, obs_next_addr, exp_next);
            end
            model_pc = exp_next;
        end
    endtask

    task automatic test_halt;
        logic [31:0] halt_pc;
        bit          held;
        run_instr(32'hFC00_0000, 0, 1, 0, 0, 0, 0, 1);
        halt_pc = obs_fetch_addr;
        vectors++;
        if (obs_valid_cycles !== 1 || obs_halted !== 1'b1 || obs_next_req !== 1'b0) begin
            miscompares++; $display("FAIL halt_entry: cycles=%0d halted=%b req=%b expected 1 1 0", obs_valid_cycles, obs_halted, obs_next_req);
        end
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            is_jmp = $urandom_range(0, 1) != 0;
            alu_zero = $urandom_range(0, 1) != 0;
            tick();
            if (imem.req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1 || pc !== halt_pc) held = 1'b0;
        end
        {is_jmp, alu_zero} = '0;
        vectors++;
        if (held !== 1'b1) begin miscompares++; $display("FAIL halt_hold: got %b expected 1 (pc=%h want %h)", held, pc, halt_pc); end
    endtask

    task automatic test_rst_mid_fetch;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (imem.req !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL rst_exit_halt: req=%b halted=%b expected 1 0", imem.req, halted); end
        tick();
        rst = 1'b1;
        imem.ack = 1'b1;
        imem.rdata = 32'h8D2A_1234;
        tick();
        rst = 1'b0;
        vectors++;
        if (imem.req !== 1'b0 || instr_valid !== 1'b0 || {opc, imm16} !== 22'd0 || pc !== BASE) begin
            miscompares++; $display("FAIL rst_mid_fetch: req=%b valid=%b opc=%h imm=%h pc=%h expected 0 0 0 0 %h",
                                    imem.req, instr_valid, opc, imm16, pc, BASE);
        end
        tick();
        imem.ack = 1'b0;
        vectors++;
        if (imem.req !== 1'b1 || instr_valid !== 1'b0 || imem.addr !== BASE || opc !== 6'd0) begin
            miscompares++; $display("FAIL late_ack_ignored: req=%b valid=%b addr=%h opc=%h expected 1 0 %h 0",
                                    imem.req, instr_valid, imem.addr, opc, BASE);
        end
        run_instr(32'h2000_0005, 1, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs_fetch_addr !== BASE || obs_next_addr !== BASE + 32'd4 || obs_opc !== 6'h08) begin
            miscompares++; $display("FAIL refetch: fetch=%h next=%h opc=%h expected %h %h 08",
                                    obs_fetch_addr, obs_next_addr, obs_opc, BASE, BASE + 32'd4);
        end
    endtask

    task automatic test_wrap;
        vectors++;
        if (w_imem.req !== 1'b1 || w_imem.addr !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'd0) begin
            miscompares++; $display("FAIL wrap_fetch: req=%b addr=%h pc_plus4=%h expected 1 fffffffc 0",
                                    w_imem.req, w_imem.addr, w_pc_plus4);
        end
        w_imem.ack = 1'b1;
        w_imem.rdata = 32'h0;
        tick();
        w_imem.ack = 1'b0;
        vectors++;
        if (w_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_exec: valid got %b expected 1", w_valid); end
        tick();
        vectors++;
        if (w_imem.req !== 1'b1 || w_imem.addr !== 32'd0) begin
            miscompares++; $display("FAIL wrap_next: req=%b addr=%h expected 1 00000000", w_imem.req, w_imem.addr);
        end
        $display("txn wrap fetch=fffffffc -> next=%h", w_imem.addr);
    endtask

    initial begin
        rst = 1'b1;
        w_tie = 1'b0;
        {is_jmp, is_beq, is_bne, alu_zero, inv_opcode, exec_stall} = '0;
        imem.ack = 1'b0;
        imem.rdata = '0;
        w_imem.ack = 1'b0;
        w_imem.rdata = '0;
        test_reset();
        test_zero_wait();
        test_branch();
        test_jump();
        test_stall_delay();
        test_random();
        test_halt();
        test_rst_mid_fetch();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
